// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared EX->MEM definitions: ALU control codes, default widths and the skid-buffer state type.
// The shifter, ALU and control unit decode the same control codes.
package ex_mem_skid_reg_pkg;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned RegAwDefault = 5;

  localparam logic [3:0] AluSra  = 4'b1000;
  localparam logic [3:0] AluSrav = 4'b1001;
  localparam logic [3:0] AluLui  = 4'b1010;

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } skid_state_e;

  function automatic logic is_shift_op(logic [3:0] ctrl);
    return (ctrl == AluSra) || (ctrl == AluSrav) || (ctrl == AluLui);
  endfunction

endpackage

// File: rtl/ex_result_sel.sv
// EX result mux: picks the shifter output for shift-class control codes, the ALU output otherwise.
module ex_result_sel
  import ex_mem_skid_reg_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic [3:0]        alu_ctrl_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] shift_result_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = alu_result_i;
    if (is_shift_op(alu_ctrl_i)) begin
      result_o = shift_result_i;
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline boundary with a 2-entry skid buffer; ready_o depends only on registered state,
// so a MEM stall never reaches EX combinationally.
module ex_mem_skid_reg
  import ex_mem_skid_reg_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned REG_AW = RegAwDefault
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        alu_ctrl_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] shift_result_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [1:0]        occ_o
);

  localparam int unsigned PayW = 2 * DATA_W + REG_AW + 3;

  skid_state_e       state_q;
  logic [PayW-1:0]   main_q;
  logic [PayW-1:0]   skid_q;
  logic [PayW-1:0]   in_pay;
  logic [DATA_W-1:0] sel_result;
  logic              accept;
  logic              deliver;
  logic              main_reg_write;
  logic              main_mem_read;
  logic              main_mem_write;

  ex_result_sel #(
    .DATA_W(DATA_W)
  ) u_result_sel (
    .alu_ctrl_i    (alu_ctrl_i),
    .alu_result_i  (alu_result_i),
    .shift_result_i(shift_result_i),
    .result_o      (sel_result)
  );

  // Result is resolved here, at capture; buffered beats are never re-selected.
  assign in_pay = {sel_result, rd_addr_i, reg_write_i, mem_read_i, mem_write_i, wdata_i};

  assign ready_o = (state_q != StFull) & rst_i;
  assign valid_o = (state_q != StEmpty);
  assign occ_o   = state_q;
  assign accept  = valid_i & ready_o;
  assign deliver = valid_o & ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      // Incoming beat is dropped even if accepted; payload may go stale, controls are gated below.
      state_q <= StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q  <= in_pay;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (accept && deliver) begin
            main_q <= in_pay;
          end else if (accept) begin
            skid_q  <= in_pay;
            state_q <= StFull;
          end else if (deliver) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (deliver) begin
            main_q  <= skid_q;
            state_q <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign {result_o, rd_addr_o, main_reg_write, main_mem_read, main_mem_write, wdata_o} = main_q;

  // Bubbles must never cause writeback or memory side effects.
  assign reg_write_o = main_reg_write & valid_o;
  assign mem_read_o  = main_mem_read & valid_o;
  assign mem_write_o = main_mem_write & valid_o;

endmodule
